// File: rtl/boxhead_soc_shared_mem_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module   : boxhead_soc_shared_mem_sweeper_if
// Brief    : Avalon-MM master/slave bundle between the sweeper and the
//            hardware-side port of the shared on-chip memory.
// Revision : 1.0 - initial release
// ============================================================================
interface boxhead_soc_shared_mem_sweeper_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, chipselect, write, byteenable, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write, byteenable, writedata,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/boxhead_soc_shared_mem_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : boxhead_soc_shared_mem_sweeper
// Brief    : On each frame_start, reads every word of the shared memory with
//            fixed 1-cycle latency and publishes them atomically as a flat
//            snapshot bus. Optional status write-back after the sweep is
//            enabled by defining BOXHEAD_SWEEPER_WRITEBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module boxhead_soc_shared_mem_sweeper #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 32,
  parameter int WB_ADDR = 7
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  input  wire logic                      frame_start,
  input  wire logic [15:0]               status_in,
  boxhead_soc_shared_mem_sweeper_if.master avm,
  output logic      [DEPTH*DATA_W-1:0]   snapshot,
  output logic                           snapshot_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           overrun
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] C_WB_ADDR  = ADDR_W'(WB_ADDR);
  localparam int                C_BE_W     = DATA_W / 8;

  logic [2:0]              r_state;
  logic [ADDR_W-1:0]       r_idx;
  logic                    r_cap;       // previous cycle was a READ
  logic [ADDR_W-1:0]       r_cap_idx;   // word address issued in that READ
  logic [15:0]             r_frame_cnt;
  logic [DEPTH*DATA_W-1:0] r_bank;      // working copy, never seen by consumers
  logic [DEPTH*DATA_W-1:0] w_next_bank;

  // Working bank with the word arriving this cycle merged in; publishing this
  // at the end of DRAIN includes the last word without an extra cycle.
  for (genvar i = 0; i < DEPTH; i++) begin : g_capture
    assign w_next_bank[i*DATA_W +: DATA_W] =
      (r_cap && (r_cap_idx == ADDR_W'(i))) ? avm.readdata : r_bank[i*DATA_W +: DATA_W];
  end

  // Sweep sequencer, capture pipeline, publish and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_cap          <= 1'b0;
      r_cap_idx      <= '0;
      r_frame_cnt    <= '0;
      r_bank         <= '0;
      snapshot       <= '0;
      snapshot_valid <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      r_cap     <= (r_state == S_READ);
      r_cap_idx <= r_idx;
      r_bank    <= w_next_bank;
      if (frame_start && (r_state != S_IDLE)) begin
        overrun <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_state <= S_READ;
            r_idx   <= '0;
          end
        end
        S_READ: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == C_LAST_IDX) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          snapshot <= w_next_bank;
`ifdef BOXHEAD_SWEEPER_WRITEBACK_EN
          r_state  <= S_WB;
`else
          r_state        <= S_DONE;
          snapshot_valid <= 1'b1;
`endif
        end
        S_WB: begin
          r_state        <= S_DONE;
          snapshot_valid <= 1'b1;
        end
        S_DONE: begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus drive decoded from state; everything idles at zero when not selected.
  always_comb begin
    avm.chipselect = 1'b0;
    avm.write      = 1'b0;
    avm.address    = '0;
    avm.writedata  = '0;
    if (r_state == S_READ) begin
      avm.chipselect = 1'b1;
      avm.address    = r_idx;
    end
`ifdef BOXHEAD_SWEEPER_WRITEBACK_EN
    if (r_state == S_WB) begin
      avm.chipselect = 1'b1;
      avm.write      = 1'b1;
      avm.address    = C_WB_ADDR;
      avm.writedata  = DATA_W'({r_frame_cnt, status_in});
    end
`endif
    avm.byteenable = avm.chipselect ? {C_BE_W{1'b1}} : {C_BE_W{1'b0}};
  end

`ifndef BOXHEAD_SWEEPER_WRITEBACK_EN
  // Frame counter and status only feed the write-back word.
  logic w_unused_fields;
  assign w_unused_fields = ^{status_in, r_frame_cnt};
`endif

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: doc/boxhead_soc_shared_mem_sweeper.md
Name: boxhead_soc_shared_mem_sweeper

Overview:
- Avalon-MM master that sits at the hardware end of the 8-word shared on-chip memory; the NIOS writes that memory through the other slave port.
- On each frame_start pulse it sweeps every word of the memory with fixed-latency reads.
- It publishes the words atomically as a flat snapshot bus for the game and render logic, so those consumers never see a half-updated frame.
- Optionally, after the sweep it writes one hardware status word back into the memory for software to read.

Parameters:
- DEPTH, 8: number of 32-bit words swept (addresses 0..DEPTH-1).
- ADDR_W, 3: memory address width; DEPTH <= 2**ADDR_W.
- DATA_W, 32: word width; byteenable width is DATA_W/8.
- WB_ADDR, 7: word address targeted by the status write-back.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  single-cycle sweep request (e.g. vsync edge).
- status_in  in  16  hardware status, sampled for write-back.
- avm_address  out  ADDR_W  master word address.
- avm_chipselect  out  1  access strobe.
- avm_write  out  1  write qualifier (0 = read).
- avm_byteenable  out  DATA_W/8  byte enables.
- avm_writedata  out  DATA_W  write data.
- avm_readdata  in  DATA_W  read data, valid exactly 1 cycle after address and chipselect.
- snapshot  out  DEPTH*DATA_W  published words; word i = bits [i*DATA_W +: DATA_W].
- snapshot_valid  out  1  high once the first sweep has completed.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse on publish.
- overrun  out  1  sticky flag: frame_start arrived while busy.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Slave model: no waitrequest; fixed read latency of 1.
- Reset values: all outputs 0, snapshot 0, frame_cnt 0, state IDLE.
- Reset mid-sweep aborts the sweep. The snapshot is not published, and the memory is left with no further access.
- avm_byteenable is all-ones whenever avm_chipselect is high, else 0.
- avm_address is 0 whenever avm_chipselect is low.
- IDLE: on frame_start, go to READ with idx = 0.
- READ:
  - drive chipselect = 1, write = 0, address = idx;
  - idx increments each cycle;
  - after idx = DEPTH-1, go to DRAIN.
- Capture: avm_readdata is captured into working word (idx-1) on every cycle after a READ cycle, which covers READ cycles 2..DEPTH plus DRAIN.
- DRAIN:
  - no access; captures the last word;
  - at the end of DRAIN, the working bank is copied to snapshot;
  - next state is WB if the write-back is enabled, else DONE.
- DONE:
  - done = 1 and snapshot_valid set; the new snapshot is visible in this same cycle;
  - frame_cnt increments, 16-bit, wrapping 0xFFFF -> 0;
  - return to IDLE.
- busy is high in READ, DRAIN, WB and DONE.
- Latency: frame_start sampled in cycle 0 gives READ in cycles 1..DEPTH, DRAIN in cycle DEPTH+1, and done in cycle DEPTH+2.
- frame_start in any state other than IDLE: ignored and overrun set. overrun clears only on reset.
- frame_start in the DONE cycle: also ignored; there is no back-to-back chaining.
- snapshot holds its value between sweeps; it only changes at publish.

Optional Feature:
- Macro: BOXHEAD_SWEEPER_WRITEBACK_EN.
- Defined:
  - state WB is inserted between DRAIN and DONE;
  - for one cycle: chipselect = 1, write = 1, address = WB_ADDR, writedata = {frame_cnt, status_in};
  - frame_cnt is the pre-increment value;
  - done moves to cycle DEPTH+3.
- Undefined: WB state is absent, avm_write is tied to 0, and avm_writedata is tied to 0.
- WB_ADDR is read during the sweep like every other word, so the snapshot shows the previous write-back.

Test Plan:
- Memory model preloaded with word i = 0xA5000000+i; frame_start pulse -> addresses 0..7 issued in cycles 1..8, done in cycle 10, snapshot word i = 0xA5000000+i, snapshot_valid = 1.
- Memory word 3 changed to 0x12345678 between sweeps; second frame_start -> only word 3 of snapshot changes, at done; snapshot stable throughout the sweep.
- frame_start reasserted in cycle 5 of a sweep -> sweep is unaffected, done still in cycle 10, overrun = 1 and sticky until reset.
- reset asserted in cycle 6 -> next cycle all outputs 0, chipselect 0, snapshot_valid 0; a new frame_start then completes normally.
- WRITEBACK_EN defined, status_in = 0x00C3, third sweep -> cycle 10 writes 0x000200C3 to address 7, done in cycle 11; the following sweep reads 0x000200C3 back as word 7.
- 65536 sweeps with WRITEBACK_EN -> write-back frame_cnt field wraps from 0xFFFF to 0x0000.
